// File: rtl/nasti_dma_scheduler_if.sv
// Command, response and mover-facing bundle of the DMA scheduler.
// The scheduler connects through the slave modport; requesters and the
// data mover (or a bench standing in for them) connect through master.
//
// Handshake rule for req_* and rsp_*: a transfer happens on a rising clock
// edge where valid and ready are both 1 for the same requester bit. Once
// valid is raised, payload is held stable until that edge. The scheduler
// drives req_ready one-hot or zero and rsp_valid one-hot or zero.
interface nasti_dma_scheduler_if #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 64
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // command side
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*ADDR_WIDTH-1:0] req_src_addr;
    logic [NREQ*ADDR_WIDTH-1:0] req_dest_addr;
    logic [NREQ*ADDR_WIDTH-1:0] req_length;

    // completion side
    logic [NREQ-1:0]            rsp_valid;
    logic [NREQ-1:0]            rsp_ready;
    logic                       rsp_err;

    // data mover side
    logic [ADDR_WIDTH-1:0]      mv_src_addr;
    logic [ADDR_WIDTH-1:0]      mv_dest_addr;
    logic [ADDR_WIDTH-1:0]      mv_length;
    logic                       mv_en;
    logic                       mv_done;

    // status and debug
    logic                       busy;
    logic [IDW-1:0]             cur_id;
    logic [31:0]                xfer_count;
    logic [1:0]                 dbg_state;

    modport slave (
        input  req_valid, req_src_addr, req_dest_addr, req_length,
        output req_ready,
        output rsp_valid, rsp_err,
        input  rsp_ready,
        output mv_src_addr, mv_dest_addr, mv_length, mv_en,
        input  mv_done,
        output busy, cur_id, xfer_count, dbg_state
    );

    modport master (
        output req_valid, req_src_addr, req_dest_addr, req_length,
        input  req_ready,
        input  rsp_valid, rsp_err,
        output rsp_ready,
        input  mv_src_addr, mv_dest_addr, mv_length, mv_en,
        output mv_done,
        input  busy, cur_id, xfer_count, dbg_state
    );
endinterface

// File: rtl/nasti_dma_scheduler.sv
// Round-robin scheduler that shares one data mover between NREQ command
// sources. Commands are checked for beat alignment and non-zero length;
// legal ones are started on the mover one at a time, illegal ones are
// answered immediately with an error response. BEAT_BYTES must be >= 2.
module nasti_dma_scheduler #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int BEAT_BYTES = 8
) (
    input logic                  aclk,
    input logic                  aresetn,
    nasti_dma_scheduler_if.slave bus
);
    localparam int SHIFT = $clog2(BEAT_BYTES);
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        cur_id_q, cur_id_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  err_q, err_d;
    logic                  arm_q, arm_d;
    logic [31:0]           xfer_count_q, xfer_count_d;

    logic                  grant_found;
    logic [IDW-1:0]        grant_id;
    logic [IDW-1:0]        cand;
    logic [ADDR_WIDTH-1:0] cmd_src, cmd_dest, cmd_len;
    logic                  cmd_illegal;
    logic [NREQ-1:0]       req_ready_c;
    logic [NREQ-1:0]       rsp_valid_c;
    logic                  mv_en_c;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % NREQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Select the granted requester's command and judge its legality.
    always_comb begin
        cmd_src  = '0;
        cmd_dest = '0;
        cmd_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_id) begin
                cmd_src  = bus.req_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_dest = bus.req_dest_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_len  = bus.req_length[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        cmd_illegal = (cmd_len == '0)
                   || (cmd_len[SHIFT-1:0]  != '0)
                   || (cmd_src[SHIFT-1:0]  != '0)
                   || (cmd_dest[SHIFT-1:0] != '0);
    end

    // Next-state logic and handshake outputs of the scheduling FSM.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_id_d     = cur_id_q;
        src_d        = src_q;
        dest_d       = dest_q;
        len_d        = len_q;
        err_d        = err_q;
        arm_d        = arm_q;
        xfer_count_d = xfer_count_q;
        req_ready_c  = '0;
        rsp_valid_c  = '0;
        mv_en_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready is offered only to the granted port, so the grant
                // itself is the handshake.
                if (grant_found) begin
                    req_ready_c[grant_id] = 1'b1;
                    src_d    = cmd_src;
                    dest_d   = cmd_dest;
                    len_d    = cmd_len;
                    cur_id_d = grant_id;
                    rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    err_d    = cmd_illegal;
                    state_d  = cmd_illegal ? S_RESP : S_START;
                end
            end
            S_START: begin
                mv_en_c = 1'b1;
                arm_d   = 1'b1;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // The mover still shows done in the cycle it takes en, so
                // the first BUSY cycle only arms the done detector.
                arm_d = 1'b0;
                if (!arm_q && bus.mv_done) begin
                    err_d        = 1'b0;
                    xfer_count_d = xfer_count_q + 32'd1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_c[cur_id_q] = 1'b1;
                if (bus.rsp_ready[cur_id_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            cur_id_q     <= '0;
            src_q        <= '0;
            dest_q       <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            arm_q        <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_id_q     <= cur_id_d;
            src_q        <= src_d;
            dest_q       <= dest_d;
            len_q        <= len_d;
            err_q        <= err_d;
            arm_q        <= arm_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.rsp_valid    = rsp_valid_c;
    assign bus.rsp_err      = (state_q == S_RESP) && err_q;
    assign bus.mv_src_addr  = src_q;
    assign bus.mv_dest_addr = dest_q;
    assign bus.mv_length    = len_q;
    assign bus.mv_en        = mv_en_c;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.cur_id       = cur_id_q;
    assign bus.xfer_count   = xfer_count_q;
    assign bus.dbg_state    = state_q;
endmodule
